// File: rtl/pong_fb_pkg.sv
// pong_fb_pkg
// Shared framebuffer geometry and the scan-reader state type.
//   FB_X_MAX   framebuffer columns
//   FB_Y_MAX   framebuffer rows
//   FB_ADDR_W  linear read-address width
//   FB_PIX_W   bits per pixel
package pong_fb_pkg;

    localparam int FB_X_MAX  = 320;
    localparam int FB_Y_MAX  = 240;
    localparam int FB_ADDR_W = 17;
    localparam int FB_PIX_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } fb_scan_state_t;

endpackage

// File: rtl/pong_delay_pipe.sv
// pong_delay_pipe
// Fixed-depth shift pipe used to align de and the pixel coordinates with
// the RAM read latency. Asynchronous reset flushes every stage to 0.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   din      in   WIDTH-bit value entering the pipe
//   dout     out  din delayed by DEPTH clocks
module pong_delay_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pong_fb_scan_reader.sv
// pong_fb_scan_reader
// Scans the framebuffer in raster order, doubling every pixel horizontally
// and every row vertically, issues linear read addresses to the framebuffer
// RAM and returns the read data aligned to the incoming display enable.
// Build option: PONG_FB_TESTPAT_EN adds input test_mode; when set, pixels
// come from an x^y pattern instead of the RAM and rd_en is held low.
// Ports:
//   clk          in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse before the first active line
//   de           in   display enable, 2*X_MAX cycles per active line
//   test_mode    in   (PONG_FB_TESTPAT_EN only) select test pattern
//   rd_en        out  RAM read strobe, same cycle as de
//   rd_addr      out  RAM read address y*X_MAX + x
//   rd_data      in   RAM data, valid RD_LAT clocks after rd_en
//   pix_valid    out  de delayed by RD_LAT
//   pix_data     out  pixel, 0 when not a valid issued pixel
//   frame_done   out  pulse after the last line of the frame
//   err          out  sticky sync error, cleared by frame_start
//
// state  | meaning
// IDLE   | out of reset, waiting for the first frame_start
// ACTIVE | scanning a frame; every de-high cycle issues one read
// DONE   | last row finished, waiting for the next frame_start
module pong_fb_scan_reader
    import pong_fb_pkg::*;
#(
    parameter int X_MAX  = FB_X_MAX,
    parameter int Y_MAX  = FB_Y_MAX,
    parameter int PIX_W  = FB_PIX_W,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              de,
`ifdef PONG_FB_TESTPAT_EN
    input  logic              test_mode,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_data,
    output logic              frame_done,
    output logic              err
);

    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam int RW = $clog2(2 * X_MAX + 1);

    fb_scan_state_t    state, state_nx;
    logic [XW-1:0]     x, x_nx;
    logic [YW-1:0]     y, y_nx;
    logic [ADDR_W-1:0] line_base, base_nx;
    logic              x_dup, x_dup_nx;
    logic              line_dup, line_dup_nx;
    logic              de_prev, de_prev_nx;
    logic [RW-1:0]     run_cnt, run_nx;
    logic              err_nx, done_nx;

    logic              tm;
    logic              issue;
    logic [XW-1:0]     x_now;
    logic [YW-1:0]     y_now;
    logic [ADDR_W-1:0] base_now;
    logic [1:0]        de_pipe_q;
    logic              issued_d;

`ifdef PONG_FB_TESTPAT_EN
    assign tm = test_mode;
`else
    assign tm = 1'b0;
`endif

    // frame_start overrides the scan position so a coincident de cycle is
    // issued as the very first pixel of the new frame.
    assign issue    = de && (frame_start || state == ACTIVE);
    assign x_now    = frame_start ? '0 : x;
    assign y_now    = frame_start ? '0 : y;
    assign base_now = frame_start ? '0 : line_base;

    assign rd_en   = issue && !tm;
    assign rd_addr = base_now + ADDR_W'(x_now);

    always_comb begin
        state_nx    = state;
        x_nx        = x;
        y_nx        = y;
        base_nx     = line_base;
        x_dup_nx    = x_dup;
        line_dup_nx = line_dup;
        de_prev_nx  = de_prev;
        run_nx      = run_cnt;
        err_nx      = err;
        done_nx     = 1'b0;

        if (frame_start) begin
            state_nx    = ACTIVE;
            x_nx        = '0;
            y_nx        = '0;
            base_nx     = '0;
            line_dup_nx = 1'b0;
            err_nx      = 1'b0;
            de_prev_nx  = de;
            x_dup_nx    = de;
            run_nx      = de ? RW'(1) : '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (de) begin
                        err_nx = 1'b1;
                    end
                end
                ACTIVE: begin
                    de_prev_nx = de;
                    if (de) begin
                        if (run_cnt != '1) begin
                            run_nx = run_cnt + RW'(1);
                        end
                        x_dup_nx = !x_dup;
                        if (x_dup) begin
                            // second copy of the last column: shift back to column 0
                            x_nx = (x == XW'(X_MAX - 1)) ? '0 : x + XW'(1);
                        end
                    end else if (de_prev) begin
                        // first de-low cycle after a run: end of a display line
                        run_nx      = '0;
                        x_nx        = '0;
                        x_dup_nx    = 1'b0;
                        line_dup_nx = !line_dup;
                        if (run_cnt != RW'(2 * X_MAX)) begin
                            err_nx = 1'b1;
                        end
                        if (line_dup) begin
                            if (y == YW'(Y_MAX - 1)) begin
                                done_nx  = 1'b1;
                                state_nx = DONE;
                            end else begin
                                y_nx    = y + YW'(1);
                                base_nx = line_base + ADDR_W'(X_MAX);
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            x_dup      <= 1'b0;
            line_dup   <= 1'b0;
            de_prev    <= 1'b0;
            run_cnt    <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            x          <= x_nx;
            y          <= y_nx;
            line_base  <= base_nx;
            x_dup      <= x_dup_nx;
            line_dup   <= line_dup_nx;
            de_prev    <= de_prev_nx;
            run_cnt    <= run_nx;
            err        <= err_nx;
            frame_done <= done_nx;
        end
    end

    // bit 1: raw de (pix_valid), bit 0: a read was actually issued
    pong_delay_pipe #(
        .WIDTH (2),
        .DEPTH (RD_LAT)
    ) u_de_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({de, issue}),
        .dout    (de_pipe_q)
    );

    assign pix_valid = de_pipe_q[1];
    assign issued_d  = de_pipe_q[0];

`ifdef PONG_FB_TESTPAT_EN
    logic [2*PIX_W-1:0] xy_d;

    pong_delay_pipe #(
        .WIDTH (2 * PIX_W),
        .DEPTH (RD_LAT)
    ) u_xy_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({x_now[PIX_W-1:0], y_now[PIX_W-1:0]}),
        .dout    (xy_d)
    );
`endif

    always_comb begin
        pix_data = '0;
        if (issued_d) begin
            pix_data = rd_data;
        end
`ifdef PONG_FB_TESTPAT_EN
        if (tm) begin
            pix_data = issued_d ? (xy_d[2*PIX_W-1:PIX_W] ^ xy_d[PIX_W-1:0]) : '0;
        end
`endif
    end

endmodule

// File: tb/tb_pong_fb_scan_reader.sv
module tb_pong_fb_scan_reader;

    localparam int BX  = 24;
    localparam int BY  = 16;
    localparam int PW  = 4;
    localparam int LAT = 2;
    localparam int AW  = 9;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          de = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          frame_done;
    logic          err;

    logic [PW-1:0] ram_q [LAT];

    int n_cmp  = 0;
    int n_fail = 0;
    int fd_cnt = 0;

    always #5 clk = ~clk;

    pong_fb_scan_reader #(
        .X_MAX  (BX),
        .Y_MAX  (BY),
        .PIX_W  (PW),
        .RD_LAT (LAT),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .de          (de),
`ifdef PONG_FB_TESTPAT_EN
        .test_mode   (1'b0),
`endif
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_done  (frame_done),
        .err         (err)
    );

    // RAM: word at address a is a[3:0], returned LAT clocks after the read
    always @(posedge clk) begin
        ram_q[0] <= rd_addr[PW-1:0];
        for (int i = 1; i < LAT; i++) ram_q[i] <= ram_q[i-1];
    end
    assign rd_data = ram_q[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position in the frame is "lines finished" and
    // "de cycles so far in this run"; address follows from the doubling rule.
    bit m_active, m_prev, m_err, m_done;
    int m_line, m_k;
    bit h_de [LAT];
    bit h_iss[LAT];
    int h_dat[LAT];
    bit e_en;
    int e_line, e_k, e_a;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (!reset_n) begin
            chk("rst_rd_en", 32'(rd_en), 0);
            chk("rst_rd_addr", 32'(rd_addr), 0);
            chk("rst_pix_valid", 32'(pix_valid), 0);
            chk("rst_pix_data", 32'(pix_data), 0);
            chk("rst_frame_done", 32'(frame_done), 0);
            chk("rst_err", 32'(err), 0);
            m_active = 0; m_prev = 0; m_err = 0; m_done = 0; m_line = 0; m_k = 0;
            for (int i = 0; i < LAT; i++) begin
                h_de[i] = 0; h_iss[i] = 0; h_dat[i] = 0;
            end
        end else begin
            e_en   = de && (frame_start || m_active);
            e_line = frame_start ? 0 : m_line;
            e_k    = frame_start ? 0 : m_k;
            e_a    = (e_line / 2) * BX + (e_k / 2) % BX;
            chk("rd_en", 32'(rd_en), 32'(e_en));
            if (e_en) chk("rd_addr", 32'(rd_addr), e_a);
            chk("pix_valid", 32'(pix_valid), 32'(h_de[LAT-1]));
            chk("pix_data", 32'(pix_data), h_iss[LAT-1] ? h_dat[LAT-1] : 0);
            chk("frame_done", 32'(frame_done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));

            m_done = 0;
            if (frame_start) begin
                m_active = 1; m_line = 0; m_err = 0; m_prev = de; m_k = de ? 1 : 0;
            end else if (m_active) begin
                if (de) begin
                    m_k++;
                end else if (m_prev) begin
                    if (m_k != 2 * BX) m_err = 1;
                    m_line++;
                    m_k = 0;
                    if (m_line == 2 * BY) begin
                        m_done = 1; m_active = 0;
                    end
                end
                m_prev = de;
            end else if (de) begin
                m_err = 1;
            end
            for (int i = LAT - 1; i > 0; i--) begin
                h_de[i] = h_de[i-1]; h_iss[i] = h_iss[i-1]; h_dat[i] = h_dat[i-1];
            end
            h_de[0] = de; h_iss[0] = e_en; h_dat[0] = e_a % 16;
        end
    end

    task automatic cycle(input logic d, input logic f);
        @(posedge clk); #1;
        de = d;
        frame_start = f;
    endtask

    task automatic drive_line(input int len, input int gap, input logic fs0,
                              output int first_a, output int last_a);
        first_a = -1;
        last_a  = -1;
        for (int i = 0; i < len; i++) begin
            cycle(1'b1, (i == 0) ? fs0 : 1'b0);
            @(negedge clk);
            if (i == 0) first_a = int'(rd_addr);
            last_a = int'(rd_addr);
        end
        for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fa, la, len, fd0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b0);

        // full frame with random blanking
        fd0 = fd_cnt;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        for (int l = 0; l < 2 * BY; l++) begin
            drive_line(2 * BX, $urandom_range(2, 6), 1'b0, fa, la);
            if (l == 0) chk("line0_first_addr", fa, 0);
            if (l == 1) chk("line1_first_addr", fa, 0);
            if (l == 2) chk("line2_first_addr", fa, 24);
            if (l == 2 * BY - 1) chk("frame_last_addr", la, 383);
        end
        repeat (4) cycle(1'b0, 1'b0);
        @(negedge clk);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("frame_err", 32'(err), 0);

        // isolated de pulse on line 2 (address 24), then short-line recovery
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        drive_line(2 * BX, 3, 1'b0, fa, la);
        drive_line(2 * BX, 3, 1'b0, fa, la);
        cycle(1'b1, 1'b0);
        @(negedge clk);
        chk("pulse_addr", 32'(rd_addr), 24);
        cycle(1'b0, 1'b0);
        @(negedge clk);
        chk("pulse_valid_t1", 32'(pix_valid), 0);
        cycle(1'b0, 1'b0);
        @(negedge clk);
        chk("pulse_valid_t2", 32'(pix_valid), 1);
        chk("pulse_data", 32'(pix_data), 8);
        chk("pulse_err", 32'(err), 1);
        cycle(1'b0, 1'b0);
        drive_line(2 * BX, 3, 1'b0, fa, la);
        chk("after_pulse_base", fa, 24);
        drive_line(2 * BX - 8, 3, 1'b0, fa, la);
        chk("short_line_base", fa, 48);
        drive_line(2 * BX, 3, 1'b0, fa, la);
        chk("after_short_base", fa, 48);
        drive_line(2 * BX, 3, 1'b0, fa, la);
        chk("after_short_next", fa, 72);
        @(negedge clk);
        chk("short_err_sticky", 32'(err), 1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        @(negedge clk);
        chk("err_cleared", 32'(err), 0);

        // mid-frame restart, then frame_start coincident with de
        for (int l = 0; l < 10; l++) drive_line(2 * BX, 2, 1'b0, fa, la);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        drive_line(2 * BX, 2, 1'b0, fa, la);
        chk("restart_addr", fa, 0);
        @(negedge clk);
        chk("restart_err", 32'(err), 0);
        drive_line(2 * BX, 2, 1'b0, fa, la);
        drive_line(2 * BX, 2, 1'b1, fa, la);
        chk("fs_de_addr", fa, 0);
        drive_line(2 * BX, 2, 1'b0, fa, la);
        chk("fs_de_dup_line", fa, 0);
        drive_line(2 * BX, 2, 1'b0, fa, la);
        chk("fs_de_row1", fa, 24);

        // reset mid-line after provoking an error
        drive_line(5, 2, 1'b0, fa, la);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        @(posedge clk); #1 reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_rd_en", 32'(rd_en), 0);
        chk("midrst_pix_valid", 32'(pix_valid), 0);
        chk("midrst_err", 32'(err), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        de = 1'b0;
        repeat (5) cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        @(negedge clk);
        chk("idle_de_err", 32'(err), 1);

        // randomized lines, lengths and restarts
        cycle(1'b0, 1'b1);
        for (int l = 0; l < 6 * BY; l++) begin
            if ($urandom_range(0, 9) < 7) len = 2 * BX;
            else len = $urandom_range(1, 2 * BX + 5);
            drive_line(len, $urandom_range(1, 5), ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0, fa, la);
            if ($urandom_range(0, 19) == 0) cycle(1'b0, 1'b1);
        end

        // clean closing frame
        cycle(1'b0, 1'b1);
        for (int l = 0; l < 2 * BY; l++) drive_line(2 * BX, $urandom_range(1, 4), 1'b0, fa, la);
        repeat (6) cycle(1'b0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
